// File: rtl/hex_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hex_digit_scanner (with companion decoder B2HConv)
// Purpose  : Time-multiplexed driver for a common-anode multi-digit
//            seven-segment display. One shared hex-to-segment decoder serves
//            all digits. The displayed value is double-buffered so that a new
//            value only takes effect at a frame boundary, which prevents
//            tearing.
// Ports    : clk       - system clock, rising edge
//            rst       - asynchronous active-high reset
//            value     - value to display, nibble k -> digit k (0 = rightmost)
//            load      - capture request, honoured only while ready=1
//            ready     - a new load can be accepted
//            blank     - forces all segments off (level, sampled each cycle)
//            segOut    - active-low segments {DP,g,f,e,d,c,b,a}
//            digitSel  - active-low one-hot anode enables
//            frameDone - one-cycle pulse after each frame wrap
// Options  : define HEX_SCAN_LEADING_ZERO_BLANK_EN to suppress leading zero
//            digits (digit 0 is always shown).
// Revision : 1.0 - initial release
// ============================================================================
module hex_digit_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic                    ready,
    input  logic                    blank,
    output logic [7:0]              segOut,
    output logic [NUM_DIGITS-1:0]   digitSel,
    output logic                    frameDone
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Load handshake: IDLE accepts a load, PENDING holds it until frame wrap.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } hs_state_t;

    hs_state_t r_state;
    hs_state_t w_state_next;

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_dig_idx;
    logic [4*NUM_DIGITS-1:0] r_hold;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_frame_done;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digit_sel;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_hold_we;
    logic                    w_shadow_we;
    logic [4*NUM_DIGITS-1:0] w_shadow_din;
    logic [3:0]              w_nibble;
    logic [7:0]              w_dec_seg;
    logic                    w_dead;
    logic                    w_suppress;

    assign w_tick = (r_div_cnt == C_DIV_MAX);
    assign w_wrap = w_tick && (r_dig_idx == C_IDX_MAX);

    // ------------------------------------------------------------------
    // Slot divider and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_dig_idx <= (r_dig_idx == C_IDX_MAX) ? '0 : r_dig_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hold_we    = 1'b0;
        w_shadow_we  = 1'b0;
        w_shadow_din = value;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    // A load landing exactly on the wrap bypasses the hold
                    // register and becomes visible in the very next frame.
                    if (w_wrap) begin
                        w_shadow_we = 1'b1;
                    end else begin
                        w_hold_we    = 1'b1;
                        w_state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (w_wrap) begin
                    w_shadow_we  = 1'b1;
                    w_shadow_din = r_hold;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign ready = (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Hold / shadow registers and frame pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_shadow     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_hold_we) begin
                r_hold <= value;
            end
            if (w_shadow_we) begin
                r_shadow <= w_shadow_din;
            end
            r_frame_done <= w_wrap;
        end
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    // Index of the most significant non-zero nibble; 0 when all nibbles are 0.
    function automatic logic [IDX_W-1:0] msd_of(input logic [4*NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[4*k +: 4] != 4'h0) begin
                m = IDX_W'(k);
            end
        end
        return m;
    endfunction

    logic [IDX_W-1:0] r_msd;

    // msd tracks the shadow register so suppression changes on frame bounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msd <= '0;
        end else if (w_shadow_we) begin
            r_msd <= msd_of(w_shadow_din);
        end
    end

    assign w_suppress = (r_dig_idx > r_msd);
`else
    assign w_suppress = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shared decoder and registered output stage
    // ------------------------------------------------------------------
    assign w_nibble = r_shadow[4*r_dig_idx +: 4];

    B2HConv u_dec (
        .nibble   (w_nibble),
        .segments (w_dec_seg)
    );

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (r_div_cnt < DIV_W'(DEAD_CYCLES));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg       <= 8'hFF;
            r_digit_sel <= '1;
        end else begin
            r_seg       <= (blank || w_suppress) ? 8'hFF : w_dec_seg;
            r_digit_sel <= w_dead ? '1 : ~(NUM_DIGITS'(1) << r_dig_idx);
        end
    end

    assign segOut    = r_seg;
    assign digitSel  = r_digit_sel;
    assign frameDone = r_frame_done;

endmodule

// ============================================================================
// Module   : B2HConv
// Purpose  : 4-bit hex to active-low seven-segment pattern, DP held off.
// Ports    : nibble   - hex digit in
//            segments - {DP,g,f,e,d,c,b,a}, active low
// Revision : 1.0 - initial release
// ============================================================================
module B2HConv (
    input  logic [3:0] nibble,
    output logic [7:0] segments
);

    always_comb begin
        segments = 8'hFF;
        case (nibble)
            4'h0: segments = 8'hC0;
            4'h1: segments = 8'hF9;
            4'h2: segments = 8'hA4;
            4'h3: segments = 8'hB0;
            4'h4: segments = 8'h99;
            4'h5: segments = 8'h92;
            4'h6: segments = 8'h82;
            4'h7: segments = 8'hF8;
            4'h8: segments = 8'h80;
            4'h9: segments = 8'h90;
            4'hA: segments = 8'h88;
            4'hB: segments = 8'h83;
            4'hC: segments = 8'hC6;
            4'hD: segments = 8'hA1;
            4'hE: segments = 8'h86;
            4'hF: segments = 8'h8E;
            default: segments = 8'hFF;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_digit_scanner
// Purpose  : Self-checking bench for hex_digit_scanner (4 digits, 4 clocks per
//            slot, 1 dead cycle). Expected outputs are queued when each cycle
//            is driven and compared after the following rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_digit_scanner;

    localparam int ND = 4;
    localparam int DV = 4;
    localparam int DC = 1;
    localparam int FRAME = ND * DV;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        ready;
    logic        blank;
    logic [7:0]  segOut;
    logic [3:0]  digitSel;
    logic        frameDone;

    hex_digit_scanner #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (DV),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .ready     (ready),
        .blank     (blank),
        .segOut    (segOut),
        .digitSel  (digitSel),
        .frameDone (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int          t;          // rising edges since reset release
    logic [15:0] m_shadow;
    logic [15:0] m_hold;
    logic        m_pend;
    logic        m_ready;

    function automatic logic [7:0] hexseg(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[n];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Drive one cycle: predict the outputs of the coming edge, push them,
    // clock, then pop and compare.
    task automatic cyc();
        exp_t       e;
        exp_t       got;
        int         dig;
        int         div;
        logic [3:0] nib;
        logic       wrap;
        logic       supp;
        div  = t % DV;
        dig  = (t / DV) % ND;
        nib  = m_shadow[dig*4 +: 4];
        supp = 1'b0;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int k = 0; k < ND; k++) begin
                if (m_shadow[k*4 +: 4] != 4'h0) msd = k;
            end
            supp = (dig > msd);
        end
`endif
        e.seg = (blank || supp) ? 8'hFF : hexseg(nib);
        e.sel = (div < DC) ? 4'hF : ~(4'b0001 << dig);
        wrap  = ((t % FRAME) == FRAME - 1);
        e.fd  = wrap;
        if (load && m_ready) begin
            if (wrap) begin
                m_shadow = value;
            end else begin
                m_hold  = value;
                m_pend  = 1'b1;
                m_ready = 1'b0;
            end
        end else if (wrap && m_pend) begin
            m_shadow = m_hold;
            m_pend   = 1'b0;
            m_ready  = 1'b1;
        end
        e.rdy = m_ready;
        sb.push_back(e);
        @(posedge clk);
        #1;
        t++;
        got = sb.pop_front();
        chk("segOut",    segOut,            got.seg);
        chk("digitSel",  {4'h0, digitSel},  {4'h0, got.sel});
        chk("frameDone", {7'h0, frameDone}, {7'h0, got.fd});
        chk("ready",     {7'h0, ready},     {7'h0, got.rdy});
    endtask

    task automatic run_to(input int target);
        while (t < target) cyc();
    endtask

    task automatic model_reset();
        t        = 0;
        m_shadow = 16'h0;
        m_hold   = 16'h0;
        m_pend   = 1'b0;
        m_ready  = 1'b1;
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"},   segOut,            8'hFF);
        chk({tag, "_sel"},   {4'h0, digitSel},  8'h0F);
        chk({tag, "_fd"},    {7'h0, frameDone}, 8'h00);
        chk({tag, "_ready"}, {7'h0, ready},     8'h01);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        blank = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Idle scanning: all zeros, two frames
        run_to(2 * FRAME);

        // Mid-frame load of 1A3F
        run_to(37);
        value = 16'h1A3F;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
        value = 16'($urandom);
        chk("ready_fell", {7'h0, ready}, 8'h00);

        // Load while busy is ignored
        run_to(40);
        value = 16'hFFFF;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
        run_to(5 * FRAME);
        chk("ready_back", {7'h0, ready}, 8'h01);

        // Load coincident with the wrap
        run_to(6 * FRAME - 1);
        value = 16'h0008;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
        value = 16'h5555;
        chk("ready_wrap_load", {7'h0, ready}, 8'h01);
        run_to(7 * FRAME);

        // Blank for one full frame, then restore
        blank = 1'b1;
        run_to(8 * FRAME);
        blank = 1'b0;
        run_to(9 * FRAME);

        // Reset mid-slot while a load is pending
        run_to(9 * FRAME + 6);
        value = 16'h1234;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
        run_to(9 * FRAME + 9);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_to(3 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
